// File: rtl/serial_frame_tx.sv
// Purpose : bit-serial frame transmitter: start(0), data LSB-first, optional even parity, stop(1).
// Latency : start bit on the line the cycle after the accepting edge; frame = DATA_W+2+PARITY_EN cycles.
// Backpress: ready only in IDLE; valid while busy is ignored (no queueing), one idle cycle between frames.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-high; abandons any frame in flight
//   valid    - data_in holds a word to send
//   data_in  - payload, sampled only on the accepting edge
//   ready    - block accepts a word this cycle (state == IDLE)
//   tx_out   - serial line, idles high
//   busy     - frame in progress (!ready)
//   done     - one-cycle pulse during the stop-bit cycle
module serial_frame_tx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int              CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_par;

  // Outputs are computed together with the next state so every port is a flop
  // that already reflects the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      tx_out  <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (valid) begin
            r_shift <= data_in;
            r_par   <= ^data_in;   // even parity: data ones + parity bit is even
            r_cnt   <= '0;
            r_state <= S_START;
            tx_out  <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end

        S_START: begin
          // Present bit 0 for the first DATA cycle; r_shift then holds the rest.
          r_state <= S_DATA;
          tx_out  <= r_shift[0];
          r_shift <= r_shift >> 1;
          r_cnt   <= '0;
        end

        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            if (PARITY_EN) begin
              r_state <= S_PARITY;
              tx_out  <= r_par;
            end else begin
              r_state <= S_STOP;
              tx_out  <= 1'b1;
              done    <= 1'b1;
            end
          end else begin
            tx_out  <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end

        S_PARITY: begin
          r_state <= S_STOP;
          tx_out  <= 1'b1;
          done    <= 1'b1;
        end

        S_STOP: begin
          r_state <= S_IDLE;
          tx_out  <= 1'b1;
          done    <= 1'b0;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end

        default: begin
          // Unreachable encodings fall back to a clean idle line.
          r_state <= S_IDLE;
          r_cnt   <= '0;
          tx_out  <= 1'b1;
          done    <= 1'b0;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid, valid_np;
  logic [7:0] data_in, data_np;
  logic       ready, tx_out, busy, done;
  logic       ready_np, tx_np, busy_np, done_np;

  serial_frame_tx #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .valid(valid), .data_in(data_in),
    .ready(ready), .tx_out(tx_out), .busy(busy), .done(done)
  );

  serial_frame_tx #(.DATA_W(8), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .reset(reset), .valid(valid_np), .data_in(data_np),
    .ready(ready_np), .tx_out(tx_np), .busy(busy_np), .done(done_np)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic tx;
    logic done;
    logic busy;
  } exp_t;

  exp_t q[$];
  exp_t q_np[$];
  logic exp_par;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected line contents for one frame, bit i = i-th cycle after acceptance.
  task automatic push_frame(input logic [7:0] d, input logic p, input bit np);
    logic [10:0] f;
    int          fl;
    exp_t        e;
    if (np) begin
      f  = {2'b00, 1'b1, d, 1'b0};
      fl = 10;
    end else begin
      f  = {1'b1, p, d, 1'b0};
      fl = 11;
    end
    for (int i = 0; i < fl; i++) begin
      e.tx   = f[i];
      e.done = (i == fl - 1);
      e.busy = 1'b1;
      if (np) q_np.push_back(e);
      else    q.push_back(e);
    end
  endtask

  // Scoreboard: compare each cycle at negedge, then enqueue a frame when the
  // coming edge will accept a word.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      q.delete();
      q_np.delete();
    end else begin
      if (q.size() > 0) e = q.pop_front();
      else              e = '{tx: 1'b1, done: 1'b0, busy: 1'b0};
      check("line_p", {tx_out, done, busy, ready}, {e.tx, e.done, e.busy, ~e.busy});
      if (q_np.size() > 0) e = q_np.pop_front();
      else                 e = '{tx: 1'b1, done: 1'b0, busy: 1'b0};
      check("line_np", {tx_np, done_np, busy_np, ready_np}, {e.tx, e.done, e.busy, ~e.busy});
      if (valid && ready)       push_frame(data_in, exp_par, 1'b0);
      if (valid_np && ready_np) push_frame(data_np, 1'b0, 1'b1);
    end
  end

  task automatic wait_ready(input bit np, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(np ? ready_np : ready) && n < 60);
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL %s: ready never seen within 60 cycles", name);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic p, input bit np);
    @(posedge clk); #1;
    if (np) begin valid_np = 1'b1; data_np = d; end
    else    begin valid = 1'b1; data_in = d; exp_par = p; end
    wait_ready(np, "send_accept");
    @(posedge clk); #1;
    // Drop valid and scramble data mid-frame; the frame on the line must not change.
    if (np) begin valid_np = 1'b0; data_np = ~d; end
    else    begin valid = 1'b0; data_in = ~d; end
    repeat (13) @(posedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;   // expected even-parity bit
  } vec_t;

  vec_t tbl[8];
  int   c1, c2;

  initial begin
    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h07, 1'b1};
    tbl[2] = '{8'h00, 1'b0};
    tbl[3] = '{8'hFF, 1'b0};
    tbl[4] = '{8'h01, 1'b1};
    tbl[5] = '{8'h80, 1'b1};
    tbl[6] = '{8'h96, 1'b0};
    tbl[7] = '{8'hFE, 1'b1};

    reset    = 1'b1;
    valid    = 1'b0;
    valid_np = 1'b0;
    data_in  = 8'h00;
    data_np  = 8'h00;
    exp_par  = 1'b0;
    #1;
    check("reset_state", {tx_out, done, busy, ready}, 4'b1001);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: scoreboard expects idle-high every cycle.
    repeat (5) @(posedge clk);

    // Table-driven frames with parity.
    for (int i = 0; i < 8; i++) send(tbl[i].d, tbl[i].p, 1'b0);

    // Back-to-back with valid held: second word taken on first ready cycle.
    @(posedge clk); #1;
    valid = 1'b1; data_in = 8'h3C; exp_par = 1'b0;
    wait_ready(1'b0, "b2b_first");
    c1 = cyc;
    @(posedge clk); #1;
    data_in = 8'hC3; exp_par = 1'b0;
    wait_ready(1'b0, "b2b_second");
    c2 = cyc;
    check("b2b_spacing", c2 - c1, 12);
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (14) @(posedge clk);

    // Asynchronous reset during data bit 4 of 0xE7 (bit 4 = 0).
    @(posedge clk); #1;
    valid = 1'b1; data_in = 8'hE7; exp_par = 1'b0;
    wait_ready(1'b0, "rst_accept");
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_bit4", {tx_out, busy}, 2'b01);
    reset = 1'b1;
    #1;
    check("async_rst", {tx_out, done, busy, ready}, 4'b1001);
    @(posedge clk); #1;
    reset = 1'b0;
    send(8'h5A, 1'b0, 1'b0);

    // No-parity instance: 10-cycle frames.
    send(8'h81, 1'b0, 1'b1);
    send(8'h3E, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    check("queues_drained", q.size() + q_np.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
